// File: rtl/risc16_pkg.sv
// risc16_pkg: opcodes, control-field encodings and FSM states for the multi-cycle RiSC-16 control unit.
package risc16_pkg;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam logic [1:0] FUNC_ADD  = 2'b00;
    localparam logic [1:0] FUNC_NAND = 2'b01;
    localparam logic [1:0] FUNC_PASS = 2'b10;
    localparam logic [1:0] FUNC_CMP  = 2'b11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [1:0] TGT_MEM = 2'b00;
    localparam logic [1:0] TGT_ALU = 2'b01;
    localparam logic [1:0] TGT_PC  = 2'b10;

    typedef enum logic [2:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
    } state_e;
endpackage

// File: rtl/risc16_decode.sv
// risc16_decode: combinational opcode to static ALU/operand/read-port select decoder.
module risc16_decode
    import risc16_pkg::*;
(
    input  logic [2:0] op_i,
    output logic [1:0] func_o,
    output logic       alu1_o,
    output logic       alu2_o,
    output logic       rf_o
);
    always_comb begin
        func_o = op_i == OP_NAND ? FUNC_NAND :
                 op_i == OP_LUI  ? FUNC_PASS :
                 op_i == OP_BEQ  ? FUNC_CMP  : FUNC_ADD;
        alu1_o = op_i == OP_LUI;
        alu2_o = op_i == OP_ADDI || op_i == OP_LW || op_i == OP_SW;
        rf_o   = op_i == OP_SW || op_i == OP_BEQ;
    end
endmodule

// File: rtl/risc16_mc_control.sv
// risc16_mc_control: multi-cycle RiSC-16 sequencer with memory handshakes, timeout,
// halt detection and a retired-instruction counter.
module risc16_mc_control
    import risc16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             EQ,
    input  logic             halt_imm,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       FUNC_alu,
    output logic             MUX_alu1,
    output logic             MUX_alu2,
    output logic [1:0]       MUX_pc,
    output logic             MUX_rf,
    output logic [1:0]       MUX_tgt,
    output logic             WE_rf,
    output logic             WE_dmem,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired
);
    localparam logic [TO_W:0] LIM = (TO_W + 1)'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [1:0]       func;
    logic             alu1, alu2, rf;
    logic             ack, req, expire, retire, live;

    risc16_decode u_dec (
        .op_i   (op),
        .func_o (func),
        .alu1_o (alu1),
        .alu2_o (alu2),
        .rf_o   (rf)
    );

    always_comb begin
        req    = state_q == S_FETCH || state_q == S_MEM;
        ack    = state_q == S_FETCH ? imem_ack : dmem_ack;
        // an ack on the limit cycle wins over the timeout
        expire = req && !ack && TIMEOUT_CYCLES != 0 && {1'b0, wait_q} + (TO_W + 1)'(1) == LIM;
        wait_d = req && !ack ? wait_q + TO_W'(1) : '0;
        retire = state_q == S_WB || (state_q == S_EXEC && op == OP_BEQ) ||
                 (state_q == S_MEM && op == OP_SW && dmem_ack);
        ret_d  = ret_q + CNT_W'(retire);
        state_d = state_q;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  state_d = expire ? S_ERROR : imem_ack ? S_DECODE : S_FETCH;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = op == OP_BEQ ? S_FETCH :
                                (op == OP_LW || op == OP_SW) ? S_MEM :
                                (op == OP_JALR && halt_imm) ? S_HALT : S_WB;
            S_MEM:    state_d = expire ? S_ERROR : !dmem_ack ? S_MEM : op == OP_SW ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        live        = state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB;
        imem_req    = state_q == S_FETCH;
        ir_we       = imem_req && imem_ack;
        dmem_req    = state_q == S_MEM;
        WE_dmem     = dmem_req && op == OP_SW;
        WE_rf       = state_q == S_WB;
        pc_we       = retire;
        FUNC_alu    = live ? func : FUNC_ADD;
        MUX_alu1    = live && alu1;
        MUX_alu2    = live && alu2;
        MUX_rf      = live && rf;
        MUX_pc      = WE_rf && op == OP_JALR ? PC_REG :
                      state_q == S_EXEC && op == OP_BEQ && EQ ? PC_BR : PC_INC;
        MUX_tgt     = !WE_rf || op == OP_LW ? TGT_MEM : op == OP_JALR ? TGT_PC : TGT_ALU;
        halted      = state_q == S_HALT;
        err_timeout = state_q == S_ERROR;
        retired     = ret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            wait_q  <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ret_q   <= ret_d;
        end
    end
endmodule

// File: tb/tb_risc16_mc_control.sv
// tb_risc16_mc_control: instruction-level trace model checked every cycle against the control unit.
module tb_risc16_mc_control;
    import risc16_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic       imem_req, dmem_req, ir_we, pc_we, we_rf, we_dmem, halted, err, mv;
        logic [1:0] mpc, mtgt, func;
        logic       alu1, alu2, rf;
        logic [2:0] ret;
    } exp_t;

    logic       clk = 0, rst_n = 0;
    logic [2:0] op = '0;
    logic       EQ = 0, halt_imm = 0, imem_ack = 0, dmem_ack = 0;
    logic       imem_req, dmem_req, ir_we, pc_we, MUX_alu1, MUX_alu2, MUX_rf, WE_rf, WE_dmem, halted, err_timeout;
    logic [1:0] FUNC_alu, MUX_pc, MUX_tgt;
    logic [2:0] retired;

    exp_t       ev = '0;
    logic       chk_en = 0;
    logic [2:0] ret_m = '0;
    int         checks = 0, errors = 0;
    logic [1:0] fn_t [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0};
    logic [7:0] a1_m = 8'h08, a2_m = 8'h32, rf_m = 8'h50;

    risc16_mc_control #(.TIMEOUT_CYCLES(TO), .TO_W(8), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .EQ(EQ), .halt_imm(halt_imm),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_we(ir_we), .pc_we(pc_we), .FUNC_alu(FUNC_alu), .MUX_alu1(MUX_alu1), .MUX_alu2(MUX_alu2),
        .MUX_pc(MUX_pc), .MUX_rf(MUX_rf), .MUX_tgt(MUX_tgt), .WE_rf(WE_rf), .WE_dmem(WE_dmem),
        .halted(halted), .err_timeout(err_timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("strobes", 32'({imem_req, dmem_req, ir_we, pc_we, WE_rf, WE_dmem, halted, err_timeout}),
            32'({ev.imem_req, ev.dmem_req, ev.ir_we, ev.pc_we, ev.we_rf, ev.we_dmem, ev.halted, ev.err}));
        chk("retired", 32'(retired), 32'(ev.ret));
        if (ev.pc_we) chk("MUX_pc", 32'(MUX_pc), 32'(ev.mpc));
        if (ev.we_rf) chk("MUX_tgt", 32'(MUX_tgt), 32'(ev.mtgt));
        if (ev.mv) chk("static_mux", 32'({FUNC_alu, MUX_alu1, MUX_alu2, MUX_rf}),
                       32'({ev.func, ev.alu1, ev.alu2, ev.rf}));
    end

    function automatic exp_t base(input logic [2:0] o);
        exp_t e = '0;
        e.mv   = 1;
        e.func = fn_t[o];
        e.alu1 = a1_m[o];
        e.alu2 = a2_m[o];
        e.rf   = rf_m[o];
        e.ret  = ret_m;
        return e;
    endfunction

    task automatic cyc(input exp_t e, input logic ia, input logic da);
        ev = e;
        imem_ack = ia;
        dmem_ack = da;
        chk_en = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_t e = '0;
        chk_en = 0;
        rst_n = 0;
        imem_ack = 0;
        dmem_ack = 0;
        @(posedge clk);
        #1;
        e.mv = 1;
        ev = e;
        chk_en = 1;
        @(posedge clk);
        #1;
        rst_n = 1;
        ret_m = '0;
        cyc(e, 1'($urandom), 1'($urandom));
    endtask

    // st: 0 retired normally, 1 halted, 2 timed out, 3 stopped early inside MEM
    task automatic instr(input logic [2:0] o, input logic eq, input logic hi, input int wi, input int wd,
                         input int abort, output int st, output int n);
        exp_t e;
        n = 0;
        st = 0;
        op = o;
        EQ = eq;
        halt_imm = hi;
        for (int k = 0; k <= wi; k++) begin
            if (k == TO) begin st = 2; return; end
            e = '0;
            e.imem_req = 1;
            e.ir_we = k == wi;
            e.ret = ret_m;
            cyc(e, k == wi, 1'($urandom));
            n++;
        end
        cyc(base(o), 1'($urandom), 1'($urandom));
        n++;
        e = base(o);
        if (o == OP_BEQ) begin
            e.pc_we = 1;
            e.mpc = eq ? 2'b01 : 2'b00;
            cyc(e, 1'($urandom), 1'($urandom));
            n++;
            ret_m++;
            return;
        end
        cyc(e, 1'($urandom), 1'($urandom));
        n++;
        if (o == OP_JALR && hi) begin st = 1; return; end
        if (o == OP_LW || o == OP_SW) begin
            for (int k = 0; k <= wd; k++) begin
                if (k == TO) begin st = 2; return; end
                if (abort != 0 && k == 2) begin st = 3; return; end
                e = base(o);
                e.dmem_req = 1;
                e.we_dmem = o == OP_SW;
                e.pc_we = o == OP_SW && k == wd;
                cyc(e, 1'($urandom), k == wd);
                n++;
            end
            if (o == OP_SW) begin ret_m++; return; end
        end
        e = base(o);
        e.we_rf = 1;
        e.pc_we = 1;
        e.mpc = o == OP_JALR ? 2'b10 : 2'b00;
        e.mtgt = o == OP_LW ? 2'b00 : o == OP_JALR ? 2'b10 : 2'b01;
        cyc(e, 1'($urandom), 1'($urandom));
        n++;
        ret_m++;
    endtask

    task automatic terminal(input int st);
        exp_t e = '0;
        e.halted = st == 1;
        e.err = st == 2;
        e.ret = ret_m;
        for (int k = 0; k < 3; k++) cyc(e, 1'($urandom), 1'($urandom));
    endtask

    initial begin
        int st, n, wi, wd;
        logic [2:0] o;
        logic hi;
        do_reset();
        instr(OP_ADD, 0, 0, 0, 0, 0, st, n);
        chk("add_cycles", 32'(n), 4);
        chk("add_retired", 32'(retired), 1);
        instr(OP_LW, 0, 0, 0, 3, 0, st, n);
        chk("lw_wait_cycles", 32'(n), 8);
        instr(OP_BEQ, 1, 0, 0, 0, 0, st, n);
        chk("beq_taken_cycles", 32'(n), 3);
        instr(OP_BEQ, 0, 0, 0, 0, 0, st, n);
        chk("beq_retired", 32'(retired), 4);
        instr(OP_ADD, 0, 0, 4, 0, 0, st, n);
        chk("fetch_timeout_status", 32'(st), 2);
        terminal(st);
        chk("err_timeout_flag", 32'(err_timeout), 1);
        chk("err_no_req", 32'(imem_req), 0);
        do_reset();
        instr(OP_ADDI, 0, 0, 3, 0, 0, st, n);
        chk("ack_at_limit_status", 32'(st), 0);
        chk("ack_at_limit_retired", 32'(retired), 1);
        instr(OP_JALR, 0, 1, 0, 0, 0, st, n);
        chk("halt_status", 32'(st), 1);
        terminal(st);
        chk("halted_flag", 32'(halted), 1);
        chk("halt_retired", 32'(retired), 1);
        do_reset();
        for (int i = 0; i < 9; i++) instr(OP_ADD, 0, 0, 0, 0, 0, st, n);
        chk("retired_wrap", 32'(retired), 1);
        do_reset();
        instr(OP_ADD, 0, 0, 0, 0, 0, st, n);
        instr(OP_SW, 0, 0, 0, 5, 1, st, n);
        chk("pre_reset_dmem_req", 32'({dmem_req, WE_dmem}), 3);
        chk_en = 0;
        rst_n = 0;
        #1;
        chk("reset_drops_dmem", 32'({dmem_req, WE_dmem}), 0);
        chk("reset_clears_retired", 32'(retired), 0);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            o = 3'($urandom_range(0, 7));
            hi = $urandom_range(0, 5) == 0;
            wi = $urandom_range(0, 11) == 0 ? $urandom_range(4, 6) : $urandom_range(0, 3);
            wd = $urandom_range(0, 11) == 0 ? $urandom_range(4, 6) : $urandom_range(0, 3);
            instr(o, 1'($urandom), hi, wi, wd, 0, st, n);
            if (st != 0) begin
                terminal(st);
                do_reset();
            end
        end
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
